// File: rtl/ram_sync_clr.sv
// Dual-port (one write, one read) synchronous RAM with byte enables, configurable read
// latency and collision policy, and a clear engine that zeroes the array after reset or on request.
module ram_sync_clr #(
  parameter int word_size  = 8,
  parameter int addr_size  = 10,
  parameter int mem_size   = 1024,
  parameter int lane_size  = 8,
  parameter int rd_latency = 1,
  parameter int rd_mode    = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cs,
  input  logic                           wr,
  input  logic [addr_size-1:0]           wr_addr,
  input  logic [word_size-1:0]           data_in,
  input  logic [word_size/lane_size-1:0] be,
  input  logic                           rd,
  input  logic [addr_size-1:0]           rd_addr,
  input  logic                           clr,
  output logic [word_size-1:0]           data_out,
  output logic                           rd_valid,
  output logic                           busy
);

  localparam int aw    = (mem_size > 1) ? $clog2(mem_size) : 1;
  localparam int lanes = word_size / lane_size;
  localparam logic [addr_size:0] mem_lim  = (addr_size+1)'(mem_size);
  localparam logic [aw-1:0]      cnt_last = aw'(mem_size - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [aw-1:0]  cnt_q, cnt_d;

  logic [word_size-1:0] mem [mem_size];

  logic                 idle;
  logic                 wr_in_range, rd_in_range;
  logic                 wr_ok, rd_go, collide;
  logic [word_size-1:0] be_mask;
  logic                 mem_we;
  logic [aw-1:0]        mem_wa;
  logic [word_size-1:0] mem_wd, mem_wm;
  logic [word_size-1:0] old_word, merged_word, rd_word;
  logic                 fin_vld;
  logic [word_size-1:0] fin_data;
  logic [word_size-1:0] data_out_q;
  logic                 rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (clr) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  assign idle        = (state_q == IDLE);
  assign busy        = ~idle;
  assign wr_in_range = ({1'b0, wr_addr} < mem_lim);
  assign rd_in_range = ({1'b0, rd_addr} < mem_lim);
  assign wr_ok       = idle & cs & wr & wr_in_range;
  assign rd_go       = idle & cs & rd;
  assign collide     = wr_ok & rd_go & (wr_addr == rd_addr);

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < lanes; i++) be_mask[i*lane_size +: lane_size] = {lane_size{be[i]}};
  end

  // The clear engine owns the single write port while busy.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_addr[aw-1:0];
    mem_wd = data_in;
    mem_wm = be_mask;
    if (!idle) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      mem_wm = '1;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= (mem[mem_wa] & ~mem_wm) | (mem_wd & mem_wm);
  end

  always_comb begin
    old_word    = rd_in_range ? mem[rd_addr[aw-1:0]] : '0;
    merged_word = (old_word & ~be_mask) | (data_in & be_mask);
    rd_word     = (rd_mode == 1 && collide) ? merged_word : old_word;
  end

  generate
    if (rd_latency == 2) begin : g_lat2
      logic                 s1_vld_q;
      logic [word_size-1:0] s1_data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld_q  <= 1'b0;
          s1_data_q <= '0;
        end else begin
          s1_vld_q <= rd_go;
          if (rd_go) s1_data_q <= rd_word;
        end
      end
      assign fin_vld  = s1_vld_q;
      assign fin_data = s1_data_q;
    end else begin : g_lat1
      assign fin_vld  = rd_go;
      assign fin_data = rd_word;
    end
  endgenerate

  // data_out only moves when a read completes; otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      rd_valid_q <= fin_vld;
      if (fin_vld) data_out_q <= fin_data;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/ram_sync_clr.md
# ram_sync_clr

Synchronous, parametrised successor to the team's asynchronous-read RAM. It has a dedicated write port and read port on one clock, and per-lane byte enables. Read latency and read/write collision behaviour are configurable. A built-in clear engine zeroes the whole array after reset or on request. It is the general-purpose buffer RAM for datapath blocks that need deterministic contents and registered outputs.

## Interface
- word_size, 8: data width in bits; must be a multiple of lane_size.
- addr_size, 10: address width.
- mem_size, 1024: number of words; must be ≤ 2**addr_size.
- lane_size, 8: bits per byte-enable lane; lanes = word_size/lane_size.
- rd_latency, 1: read latency in cycles; legal values are 1 or 2.
- rd_mode, 0: collision policy. 0 = read-first (old data); 1 = write-first (new data).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  1  chip select; gates both ports.
- wr  input  1  write request.
- wr_addr  input  addr_size  write address.
- data_in  input  word_size  write data.
- be  input  lanes  byte enables; lane i covers bits [i*lane_size +: lane_size].
- rd  input  1  read request.
- rd_addr  input  addr_size  read address.
- clr  input  1  clear request; single-cycle pulse.
- data_out  output  word_size  registered read data.
- rd_valid  output  1  data_out holds the result of a read issued rd_latency cycles earlier.
- busy  output  1  clear engine active; all port requests are ignored.

## Operation
- **FSM states:** CLEAR and IDLE.
- **Reset (rst_n=0):** immediate, asynchronous.
  - state=CLEAR, clear counter=0.
  - busy=1, rd_valid=0, data_out=0.
  - Read pipeline valid bits cleared.
  - Array contents are not reset directly; the clear engine zeroes them.
- **CLEAR:**
  - Each cycle, writes 0 to mem[counter], then counter+1.
  - After writing address mem_size-1: counter→0, state→IDLE, busy→0 on that same edge.
  - wr, rd and clr are ignored. No rd_valid is generated.
- **IDLE, write:** when cs&wr and wr_addr<mem_size, update each lane i where be[i]=1; other lanes keep their value.
- **IDLE, read:** when cs&rd and rd_addr<mem_size, launch a read.
- **Out-of-range addresses (≥mem_size):**
  - Writes are dropped.
  - Reads still produce rd_valid, with data_out=0.
- **IDLE, clear request:** when clr=1, state→CLEAR and busy=1 from the next edge. Any wr/rd in the same cycle is still serviced.
- **Collision:** cs&wr&rd with wr_addr==rd_addr in the same cycle.
  - rd_mode=0: read returns the pre-write word.
  - rd_mode=1: read returns the merged word (lanes with be=1 from data_in, others old).
- **data_out hold:** data_out holds its last value whenever rd_valid=0. It is not forced to 0.
- **Read pipeline:** shifts every cycle, with no stall or backpressure.
- **Reads in flight when clr is accepted:** still complete and assert rd_valid.

## Timing
- **Read issued at edge N:**
  - rd_latency=1: data_out and rd_valid are valid after edge N+1.
  - rd_latency=2: valid after edge N+2.
  - rd_valid is high for exactly one cycle per accepted read.
- **Back-to-back reads:** one accepted per cycle, giving a continuous rd_valid stream.
- **Write at edge N:** visible to a read issued at edge N+1 or later, regardless of rd_mode.
- **Clear duration:** exactly mem_size cycles.
  - After rst_n rises, busy falls at the mem_size-th rising edge.
  - The first accepted request is at the following edge.
- **Reset mid-clear:** asserting rst_n restarts the clear from address 0; there is no partial resume.
- **clr while busy:** ignored; it does not extend or restart the clear.

## Test plan
- **Power-up clear:** mem_size=16. Release rst_n → busy=1 for 16 cycles then 0. Reads of addr 0..15 → data_out=0x00 with rd_valid=1, one cycle after each rd.
- **Basic write/read:** rd_latency=2. Write 0xA5 to addr 3, then read addr 3 → rd_valid and data_out=0xA5 two cycles after rd. Reads of addr 2 and 4 → 0x00.
- **Byte enables:** word_size=16. Write 0x1234 be=2'b11 to addr 7, then 0xABCD be=2'b01 → read returns 0x12CD.
- **Collision:** addr 5 holds 0x11. Same cycle: write 0x22 be=1 and read addr 5 → rd_mode=0 returns 0x11; rd_mode=1 returns 0x22. A following read returns 0x22 in both modes.
- **Reset mid-clear:** assert rst_n after 5 clear cycles, release → busy stays high a full 16 cycles. A wr of 0x5A pulsed during busy is ignored; a later read returns 0x00.
- **Clear on request:** fill addr 0..15 with 0xFF, pulse clr with rd of addr 1 in the same cycle → that read returns 0xFF. Busy for 16 cycles, then all addresses read 0x00. A second clr pulse during busy does not extend the clear.
